// File: rtl/alu_iterative_exec_if.sv
// Request/response bundle for the iterative ALU: operand handshake in, result handshake out.
interface alu_iterative_exec_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       ALUControl;
  logic [WIDTH-1:0] SrcA;
  logic [WIDTH-1:0] SrcB;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] ALUResult;
  logic             Zero;
  logic             Illegal;

  modport master (
    output in_valid, ALUControl, SrcA, SrcB, out_ready,
    input  in_ready, out_valid, ALUResult, Zero, Illegal
  );

  modport slave (
    input  in_valid, ALUControl, SrcA, SrcB, out_ready,
    output in_ready, out_valid, ALUResult, Zero, Illegal
  );
endinterface

// File: rtl/alu_iterative_exec.sv
// Multi-cycle ALU: logic/arithmetic ops complete in one cycle, shifts move one bit per cycle.
module alu_iterative_exec #(
  parameter int WIDTH = 32
) (
  input logic                clk,
  input logic                reset,
  alu_iterative_exec_if.slave bus
);

  localparam int SHW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  typedef enum logic [1:0] {SH_LL, SH_RL, SH_RA} shop_t;
  typedef enum logic [3:0] {
    OP_ADD  = 4'b0000,
    OP_SUB  = 4'b0001,
    OP_AND  = 4'b0010,
    OP_OR   = 4'b0011,
    OP_XOR  = 4'b0100,
    OP_SLT  = 4'b0101,
    OP_SLL  = 4'b0110,
    OP_SRL  = 4'b0111,
    OP_SRA  = 4'b1000,
    OP_SLTU = 4'b1001
  } op_t;

  state_t           state, state_n;
  shop_t            shop, shop_n;
  logic [WIDTH-1:0] work, work_n;
  logic [WIDTH-1:0] res, res_n;
  logic [SHW-1:0]   cnt, cnt_n;
  logic             zero, zero_n;
  logic             ill, ill_n;
  logic [SHW-1:0]   shamt;

  function automatic logic [WIDTH-1:0] shift1(input shop_t s, input logic [WIDTH-1:0] w);
    case (s)
      SH_LL:   return {w[WIDTH-2:0], 1'b0};
      SH_RL:   return {1'b0, w[WIDTH-1:1]};
      default: return {w[WIDTH-1], w[WIDTH-1:1]};
    endcase
  endfunction

  assign shamt = bus.SrcB[SHW-1:0];

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      shop  <= SH_LL;
      work  <= '0;
      res   <= '0;
      cnt   <= '0;
      zero  <= 1'b0;
      ill   <= 1'b0;
    end else begin
      state <= state_n;
      shop  <= shop_n;
      work  <= work_n;
      res   <= res_n;
      cnt   <= cnt_n;
      zero  <= zero_n;
      ill   <= ill_n;
    end
  end

  always_comb begin
    state_n = state;
    shop_n  = shop;
    work_n  = work;
    res_n   = res;
    cnt_n   = cnt;
    zero_n  = zero;
    ill_n   = ill;

    case (state)
      IDLE: begin
        if (bus.in_valid) begin
          state_n = DONE;
          ill_n   = 1'b0;
          case (bus.ALUControl)
            OP_ADD:  res_n = bus.SrcA + bus.SrcB;
            OP_SUB:  res_n = bus.SrcA - bus.SrcB;
            OP_AND:  res_n = bus.SrcA & bus.SrcB;
            OP_OR:   res_n = bus.SrcA | bus.SrcB;
            OP_XOR:  res_n = bus.SrcA ^ bus.SrcB;
            OP_SLT:  res_n = WIDTH'($signed(bus.SrcA) < $signed(bus.SrcB));
            OP_SLTU: res_n = WIDTH'(bus.SrcA < bus.SrcB);
            OP_SLL, OP_SRL, OP_SRA: begin
              // Zero shift amount bypasses the iteration and returns SrcA directly.
              if (shamt == '0) begin
                res_n = bus.SrcA;
              end else begin
                state_n = SHIFT;
                work_n  = bus.SrcA;
                cnt_n   = shamt;
                case (bus.ALUControl)
                  OP_SLL:  shop_n = SH_LL;
                  OP_SRL:  shop_n = SH_RL;
                  default: shop_n = SH_RA;
                endcase
              end
            end
            default: begin
              res_n = '0;
              ill_n = 1'b1;
            end
          endcase
          if (state_n == DONE) zero_n = (res_n == '0);
        end
      end

      SHIFT: begin
        work_n = shift1(shop, work);
        cnt_n  = cnt - 1'b1;
        if (cnt == SHW'(1)) begin
          state_n = DONE;
          res_n   = shift1(shop, work);
          zero_n  = (shift1(shop, work) == '0);
        end
      end

      DONE: begin
        if (bus.out_ready) state_n = IDLE;
      end

      default: state_n = IDLE;
    endcase
  end

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.ALUResult = res;
  assign bus.Zero      = zero;
  assign bus.Illegal   = ill;

endmodule

// File: doc/alu_iterative_exec.md
# alu_iterative_exec

Multi-cycle ALU execution unit that consumes the 4-bit `ALUControl` code produced by the ALU decoder, together with two operands, and returns a registered result through valid/ready handshakes. Logic/arithmetic ops finish in one cycle; shifts iterate one bit position per cycle to save area. It sits between operand fetch and writeback in the multi-cycle variant of the core, on the receiving end of the decoder's `ALUControl` output.

## Interface
- `WIDTH`, default 32: operand/result width; power of two, ≥ 8.
- `clk`  input  1  rising-edge clock.
- `reset`  input  1  synchronous, active-high reset.
- `in_valid`  input  1  operands and `ALUControl` valid.
- `in_ready`  output  1  unit can accept a request.
- `ALUControl`  input  4  operation code from the ALU decoder.
- `SrcA`  input  WIDTH  operand A.
- `SrcB`  input  WIDTH  operand B; low log2(WIDTH) bits are shift amount for shifts.
- `out_valid`  output  1  result valid.
- `out_ready`  input  1  consumer accepts result.
- `ALUResult`  output  WIDTH  registered result.
- `Zero`  output  1  `ALUResult == 0`, registered with result.
- `Illegal`  output  1  request carried an unassigned `ALUControl` code.

## Operation
- `ALUControl` encoding: 0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 XOR, 0101 SLT (signed), 0110 SLL, 0111 SRL, 1000 SRA, 1001 SLTU; 1010–1111 illegal.
- ADD/SUB modulo 2^WIDTH, no overflow flag. SLT/SLTU: result = {WIDTH-1 zeros, compare bit}.
- States: IDLE, SHIFT, DONE.
- IDLE: `in_ready`=1. On `in_valid & in_ready`, capture `ALUControl`, `SrcA`, `SrcB`.
  - Non-shift op (legal or illegal): compute, load result/`Zero`/`Illegal`, go DONE.
  - Shift op with shamt=0: result=`SrcA`, go DONE.
  - Shift op with shamt=k>0: load working register with `SrcA`, counter=k, go SHIFT.
- SHIFT: each cycle shift working register 1 bit (SLL: zero in at LSB; SRL: zero in at MSB; SRA: replicate MSB), decrement counter; on the cycle counter goes 1→0, go DONE with final result/`Zero`.
- DONE: `out_valid`=1; `ALUResult`, `Zero`, `Illegal` held stable until `out_ready`=1, then go IDLE.
- Illegal code: `ALUResult`=0, `Zero`=1, `Illegal`=1; handshake completes normally.
- `in_ready`=0 in SHIFT and DONE; inputs ignored there.

## Timing
- Reset (any state, including mid-shift): state IDLE, `in_ready`=1, `out_valid`=0, `ALUResult`=0, `Zero`=0, `Illegal`=0, counter=0; in-flight request discarded.
- Accept at edge N: non-shift or shamt=0 → `out_valid`=1 in cycle N+1; shift by k → `out_valid`=1 in cycle N+1+k.
- Output handshake completes on the edge where `out_valid & out_ready`; `in_ready` returns to 1 the following cycle (no same-cycle accept from DONE). Minimum 2 cycles per request.
- `out_ready` low: result held indefinitely, no change to any output.
- `in_ready` does not depend combinationally on `out_ready`; all outputs are registered or state-decoded.
- `out_valid` never deasserts without handshake or reset.

## Test plan
- ADD `SrcA`=5, `SrcB`=7, `out_ready`=1 → `out_valid` one cycle after accept, `ALUResult`=12, `Zero`=0; SUB 3−3 → 0, `Zero`=1.
- SLT `SrcA`=0xFFFFFFFF, `SrcB`=1 → 1; SLTU same operands → 0, `Zero`=1.
- SRA `SrcA`=0x80000000, `SrcB`=4 → `out_valid` 5 cycles after accept, `ALUResult`=0xF8000000; SRL same → 0x08000000; SLL by 0 → `SrcA` after 1 cycle.
- Backpressure: OR 0xF0 | 0x0F with `out_ready`=0 for 10 cycles → `out_valid` stays 1, `ALUResult`=0xFF stable, `in_ready`=0; raise `out_ready` → handshake, `in_ready`=1 next cycle.
- Reset asserted 3 cycles into SLL by 31 → next cycle IDLE, `out_valid`=0, all outputs 0; new ADD afterwards completes correctly.
- `ALUControl`=1111 → `ALUResult`=0, `Zero`=1, `Illegal`=1, normal 1-cycle latency; following legal op clears `Illegal`.
